// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Bits needed to hold a down-counter starting at width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_ADJ_THRESH) begin
            dout = din + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Optional BIN2BCD_AUTO_EN: start a conversion automatically whenever bin changes.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned SW = 4 * DIGITS + WIDTH;

    state_e          state, state_next;
    logic            accept;
    logic            auto_go;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   scratch_adj;

    // Binary part passes through; each BCD field is corrected before shifting.
    assign scratch_adj[WIDTH-1:0] = scratch[WIDTH-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[WIDTH+4*g +: 4]),
            .dout (scratch_adj[WIDTH+4*g +: 4])
        );
    end

`ifdef BIN2BCD_AUTO_EN
    logic [WIDTH-1:0] last_bin;
    logic             last_valid;

    assign auto_go = !last_valid || (bin != last_bin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_bin   <= '0;
            last_valid <= 1'b0;
        end else if (accept) begin
            last_bin   <= bin;
            last_valid <= 1'b1;
        end
    end
`else
    assign auto_go = 1'b0;
`endif

    assign accept = (state == IDLE) && (start || auto_go);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            scratch <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        scratch <= {{(4 * DIGITS){1'b0}}, bin};
                        cnt     <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    scratch <= {scratch_adj[SW-2:0], 1'b0};
                    cnt     <= cnt - 1'b1;
                end
                LOAD: begin
                    bcd  <= scratch[SW-1 -: 4 * DIGITS];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq; the BIN2BCD_AUTO_EN build runs the auto-start sequence.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] prev_bcd;

    bin2bcd_seq #(
        .WIDTH  (9),
        .DIGITS (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    // Decimal digits straight from integer division.
    function automatic logic [11:0] model(input int v);
        logic [11:0] r;
        r[11:8] = 4'((v / 100) % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < limit);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

`ifndef BIN2BCD_AUTO_EN
    typedef struct {
        logic [8:0]  bin;
        logic [11:0] exp;
    } vec_t;

    // One conversion; optionally pulses start with a new bin at cycle inj_at of the conversion.
    task automatic run_conv(input logic [8:0] v, input logic [11:0] exp, input int inj_at,
                            input logic [8:0] inj_bin, input string name);
        int   n;
        logic busy_ok;
        logic hold_ok;
        logic got;
        bin   = v;
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        n       = 0;
        busy_ok = busy;
        hold_ok = 1'b1;
        got     = 1'b0;
        while (n < 40 && !got) begin
            if (n == inj_at) begin
                bin   = inj_bin;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (bcd !== prev_bcd) hold_ok = 1'b0;
            end
        end
        start = 1'b0;
        check({name, " latency"}, n, 10);
        check({name, " busy"}, busy_ok, 1'b1);
        check({name, " hold"}, hold_ok, 1'b1);
        check({name, " bcd"}, bcd, exp);
        prev_bcd = exp;
        @(posedge clk); #1;
        check({name, " done_pulse"}, {busy, done}, 2'b00);
    endtask

    initial begin
        vec_t vecs[10];
        int   n;
        logic [8:0] r;

        vecs[0] = '{9'd0,   12'h000};
        vecs[1] = '{9'd510, 12'h510};
        vecs[2] = '{9'd1,   12'h001};
        vecs[3] = '{9'd9,   12'h009};
        vecs[4] = '{9'd10,  12'h010};
        vecs[5] = '{9'd99,  12'h099};
        vecs[6] = '{9'd100, 12'h100};
        vecs[7] = '{9'd511, 12'h511};
        vecs[8] = '{9'd399, 12'h399};
        vecs[9] = '{9'd42,  12'h042};

        rst   = 1'b1;
        start = 1'b0;
        bin   = 9'd0;
        #12;
        check("reset", {busy, done, bcd}, 14'h0);
        rst      = 1'b0;
        prev_bcd = 12'h000;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].bin, vecs[i].exp, -1, 9'd0, $sformatf("vec%0d", i));
        end

        // start during a conversion is ignored
        run_conv(9'd255, 12'h255, 4, 9'd7, "ignore_start");
        check("ignore_start idle", busy, 1'b0);

        // async reset mid-conversion
        bin   = 9'd399;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("pre_reset busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("async reset", {busy, done, bcd}, 14'h0);
        #2;
        rst      = 1'b0;
        prev_bcd = 12'h000;
        @(posedge clk); #1;
        run_conv(9'd42, 12'h042, -1, 9'd0, "after_reset");

        // start held high: back-to-back conversions
        bin   = 9'd100;
        start = 1'b1;
        wait_done(40, n);
        check("held first bcd", bcd, 12'h100);
        bin = 9'd101;
        wait_done(40, n);
        start = 1'b0;
        check("held spacing", n, 11);
        check("held second bcd", bcd, 12'h101);
        count_dones(15, n);
        check("held stopped", n, 0);
        prev_bcd = 12'h101;

        for (int i = 0; i < 16; i++) begin
            r = 9'($urandom_range(0, 511));
            run_conv(r, model(int'(r)), -1, 9'd0, $sformatf("rand%0d_%0d", i, r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
`else
    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        bin   = 9'd37;
        #12;
        check("reset", {busy, done, bcd}, 14'h0);
        rst = 1'b0;
        wait_done(40, n);
        check("auto first done", done, 1'b1);
        check("auto 37", bcd, 12'h037);
        count_dones(30, n);
        check("auto stable", n, 0);
        bin = 9'd38;
        wait_done(40, n);
        check("auto second done", done, 1'b1);
        check("auto 38", bcd, 12'h038);
        count_dones(30, n);
        check("auto stable2", n, 0);
        for (int i = 0; i < 8; i++) begin
            bin = 9'($urandom_range(0, 511));
            wait_done(40, n);
            check($sformatf("auto rand%0d", i), bcd, model(int'(bin)));
            count_dones(12, n);
            check($sformatf("auto rand%0d quiet", i), n, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
`endif

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly downstream of the 8-bit switch adder: consumes its 9-bit registered sum (0..510) and produces decimal digits for the hex2sev_segm display drivers.
- Start/busy/done handshake, so the adder result can be shown in decimal instead of hex.

Parameters:
- WIDTH, 9, width of binary input.
- DIGITS, 3, number of BCD output digits; integrator guarantees 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- start  in  1  conversion request, sampled on clk while idle.
- bin  in  WIDTH  binary value, sampled on the clk edge where start is accepted.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse, bcd updated.
- bcd  out  4*DIGITS  result, digit k at bits [4k+3:4k], k=0 is units.

Behaviour:
- States: IDLE, SHIFT, LOAD.
- Reset (async, any state, mid-conversion included): state=IDLE, bcd=0, busy=0, done=0, bit counter=0, scratch=0.
- IDLE, start=1 at edge t: scratch = {DIGITS*4 zeros, bin}, counter=WIDTH, state->SHIFT, busy=1.
- SHIFT, edges t+1..t+WIDTH:
  - Each digit field of scratch >=5 gets +3 (4-bit, no carry out).
  - Then the whole scratch shifts left 1; counter decrements.
  - Counter reaching 0 -> LOAD.
- LOAD, edge t+WIDTH+1:
  - bcd <= upper 4*DIGITS bits of scratch, done=1 for exactly one cycle, busy=0, state->IDLE.
  - Latency start-edge to done: WIDTH+1 clocks, 10 for defaults.
- bcd holds the previous result for the whole conversion and changes only at LOAD.
- start while busy (SHIFT or LOAD): ignored, no queueing; bin changes during conversion have no effect.
- start high in the cycle done is high (state IDLE) is accepted: back-to-back throughput WIDTH+2 clocks per result.
- start held high continuously: a new conversion is accepted at every IDLE visit.
- bin = 0 gives bcd = 0; bin = 2^WIDTH-1 converts exactly when the DIGITS constraint holds. Behaviour with the constraint violated is undefined.

Optional Feature:
- Macro: BIN2BCD_AUTO_EN.
- Defined:
  - Internal register last_bin (WIDTH bits) plus a valid flag, both cleared by rst.
  - In IDLE, a conversion starts automatically when the valid flag is 0 or bin != last_bin. This is ORed with the start port.
  - last_bin <= bin and valid <= 1 at acceptance, so the display tracks the adder sum with no strobe.
- Undefined: no last_bin register; conversions start only from the start port.

Decomposition:
- Shared package:
  - State encoding constants (IDLE=2'd0, SHIFT=2'd1, LOAD=2'd2).
  - BCD_ADJ_THRESH=4'd5, BCD_ADJ_ADD=4'd3.
  - Counter-width function clog2(WIDTH+1).
- One sub-module: bcd_digit_adj, combinational 4-bit in -> 4-bit out (+3 if >=5), instanced DIGITS times via generate on the scratch digit fields.
- Top holds the FSM, counter, scratch and output registers.

Test Plan:
- Reset then start with bin=9'd0 -> done pulses exactly 10 clocks after the start edge, bcd=12'h000, busy high for the intervening cycles.
- bin=9'd510 (0xFF+0xFF) -> bcd=12'h510, single-cycle done; bcd keeps its previous value until the LOAD edge.
- bin=9'd255, then bin changed to 9'd7 and start pulsed at cycle 4 of the conversion -> ignored, result bcd=12'h255.
- Assert rst at cycle 5 of a bin=9'd399 conversion -> busy, done, bcd=0 immediately (asynchronously); subsequent start bin=9'd42 -> bcd=12'h042.
- start held high, bin=9'd100 then 9'd101 -> consecutive done pulses 11 clocks apart, bcd=12'h100 then 12'h101.
- With BIN2BCD_AUTO_EN, start tied 0:
  - After reset, bin=9'd37 -> bcd=12'h037.
  - bin stable -> no further done.
  - bin->9'd38 -> one conversion, bcd=12'h038.
